// File: rtl/gate_truth_table_checker_pkg.sv
// Shared types and constants for gate_truth_table_checker: FSM state encoding,
// truth-table width helper and default 2-input truth tables.
package gate_chk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      SAMPLE,
      DONE
   } chk_state_t;

   function automatic int unsigned pow2(input int unsigned n);
      return 32'd1 << n;
   endfunction

   // Bit i is the gate output for input vector i (bit 0 = a, bit 1 = b).
   localparam logic [3:0] AND_TT = 4'b1000;
   localparam logic [3:0] OR_TT  = 4'b1110;
   localparam logic [3:0] XOR_TT = 4'b0110;

endpackage

// File: rtl/gate_truth_table_checker.sv
// Clocked stimulus-and-check engine that sweeps every input vector of a small
// combinational gate and compares its output against a truth table.
// Optional macro GATE_CHK_STOP_ON_FAIL_EN: end the run at the first mismatch.
module gate_truth_table_checker
   import gate_chk_pkg::*;
#(
   parameter int unsigned                 NUM_INPUTS    = 2,
   parameter logic [pow2(NUM_INPUTS)-1:0] EXPECTED      = AND_TT,
   parameter int unsigned                 SETTLE_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic [NUM_INPUTS-1:0] stim,
   input  logic                  dut_y,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [NUM_INPUTS:0]   fail_count,
   output logic [NUM_INPUTS-1:0] first_fail
);

   localparam int unsigned NUM_VEC = pow2(NUM_INPUTS);
   localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned FC_W    = NUM_INPUTS + 1;

   localparam logic [CNT_W-1:0]      SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [NUM_INPUTS-1:0] LAST_IDX    = NUM_INPUTS'(NUM_VEC - 1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
   localparam bit STOP_ON_FAIL = 1'b1;
`else
   localparam bit STOP_ON_FAIL = 1'b0;
`endif

   chk_state_t            state_q, state_d;
   logic [NUM_INPUTS-1:0] idx_q, idx_d;
   logic [CNT_W-1:0]      settle_q, settle_d;
   logic [FC_W-1:0]       fail_q, fail_d;
   logic [NUM_INPUTS-1:0] first_q, first_d;
   logic                  busy_q, done_q;
   logic                  mismatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         settle_q <= '0;
         fail_q   <= '0;
         first_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         fail_q   <= fail_d;
         first_q  <= first_d;
         busy_q   <= (state_d == SETTLE) || (state_d == SAMPLE);
         done_q   <= (state_d == DONE);
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      fail_d   = fail_q;
      first_d  = first_q;
      mismatch = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d  = SETTLE;
               idx_d    = '0;
               settle_d = SETTLE_LOAD;
               fail_d   = '0;
               first_d  = '0;
            end
         end
         SETTLE: begin
            if (settle_q == '0) state_d = SAMPLE;
            else                settle_d = settle_q - CNT_W'(1);
         end
         SAMPLE: begin
            // Case inequality so an X/Z from the gate is reported as a failure.
            mismatch = (dut_y !== EXPECTED[idx_q]);
            if (mismatch) begin
               fail_d = fail_q + FC_W'(1);
               if (fail_q == '0) first_d = idx_q;
            end
            if ((mismatch && STOP_ON_FAIL) || (idx_q == LAST_IDX)) begin
               state_d = DONE;
            end else begin
               idx_d    = idx_q + NUM_INPUTS'(1);
               settle_d = SETTLE_LOAD;
               state_d  = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign stim       = idx_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign fail_count = fail_q;
   assign first_fail = first_q;
   assign pass       = done_q && (fail_q == '0);

endmodule
